// File: rtl/softermax_pkg.sv
// Shared types, widths and reciprocal LUT contents for the Softermax reciprocal stage.
// LUT scale: for mantissa x in [1,2) the intercept is 2^18/x at each 1/8 segment start,
// and the slope is the intercept difference across one segment.
package softermax_pkg;

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned M_W    = 16;
  localparam int unsigned C_W    = 32;
  localparam int unsigned EXP_W  = 6;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned PROD_W = M_W + FRAC_W + 1;

  typedef logic [SEL_W-1:0] recip_sel_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] prod;
    logic signed [C_W-1:0]    c;
    logic signed [EXP_W-1:0]  exp;
    logic                     dz;
  } recip_s2_t;

  // Slope per segment: C[s+1] - C[s].
  function automatic logic signed [M_W-1:0] recip_slope(input recip_sel_t sel);
    case (sel)
      4'd0:    return -16'sd29128;
      4'd1:    return -16'sd23301;
      4'd2:    return -16'sd19065;
      4'd3:    return -16'sd15888;
      4'd4:    return -16'sd13443;
      4'd5:    return -16'sd11523;
      4'd6:    return -16'sd9986;
      4'd7:    return -16'sd8738;
      default: return '0;
    endcase
  endfunction

  // Intercept per segment: floor(2^21 / (8 + s)).
  function automatic logic signed [C_W-1:0] recip_intercept(input recip_sel_t sel);
    case (sel)
      4'd0:    return 32'sd262144;
      4'd1:    return 32'sd233016;
      4'd2:    return 32'sd209715;
      4'd3:    return 32'sd190650;
      4'd4:    return 32'sd174762;
      4'd5:    return 32'sd161319;
      4'd6:    return 32'sd149796;
      4'd7:    return 32'sd139810;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/softermax_lod.sv
// Combinational leading-one detector: index of the most significant set bit.
module softermax_lod #(
  parameter int unsigned Width = 16,
  localparam int unsigned IdxW = $clog2(Width)
) (
  input  logic [Width-1:0] den_i,
  output logic [IdxW-1:0]  p_o,
  output logic             found_o
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    p_o     = '0;
    found_o = 1'b0;
    for (int i = 0; i < Width; i++) begin
      if (den_i[i]) begin
        p_o     = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/softermax_recip_unit.sv
// Softermax reciprocal stage: normalize -> LUT lookup/multiply -> add/slice, 3-stage pipeline
// with valid/ready backpressure. Define SOFTERMAX_RECIP_ROUND_EN for round-half-up in the
// final slice instead of truncation.
module softermax_recip_unit
  import softermax_pkg::*;
#(
  parameter int unsigned DEN_W      = 16,
  parameter int unsigned DEN_FRAC   = 8,
  parameter int unsigned RECIP_W    = 16,
  parameter int unsigned PROD_SHIFT = 12,
  parameter int unsigned RES_LSB    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DEN_W-1:0]   in_den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RECIP_W-1:0] out_recip,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_dz
);

  localparam int unsigned LodW    = $clog2(DEN_W);
  // The leading one is implicit after normalization, so only the bits below it are kept.
  localparam int unsigned MantW   = DEN_W - 1;
  localparam int unsigned SliceHi = RES_LSB + RECIP_W;
`ifdef SOFTERMAX_RECIP_ROUND_EN
  localparam logic [C_W-1:0] RoundAdd = C_W'(1) << (RES_LSB - 1);
`else
  localparam logic [C_W-1:0] RoundAdd = '0;
`endif

  logic [LodW-1:0] lod_p;
  logic            lod_found;

  logic                    s1_valid_q, s1_valid_d;
  logic [MantW-1:0]        s1_mant_q, s1_mant_d;
  logic signed [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic                    s1_dz_q, s1_dz_d;

  logic      s2_valid_q, s2_valid_d;
  recip_s2_t s2_q, s2_d;

  logic               out_valid_q, out_valid_d;
  logic [RECIP_W-1:0] out_recip_q, out_recip_d;
  logic [EXP_W-1:0]   out_exp_q, out_exp_d;
  logic               out_dz_q, out_dz_d;

  logic s1_adv, s2_adv, s3_adv;

  recip_sel_t              s2_sel;
  logic [FRAC_W-1:0]       s2_frac;
  logic signed [M_W-1:0]   s2_slope;
  logic signed [PROD_W-1:0] s3_prod_sh;
  logic [C_W-1:0]          s3_sum;
  logic [RECIP_W-1:0]      s3_recip;

  softermax_lod #(
    .Width(DEN_W)
  ) u_lod (
    .den_i  (in_den),
    .p_o    (lod_p),
    .found_o(lod_found)
  );

  // A stage moves when it is empty or the stage after it moves.
  assign s3_adv   = out_ready | ~out_valid_q;
  assign s2_adv   = ~s2_valid_q | s3_adv;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // S1: capture and normalize so the leading one sits at the top.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_dz_d    = s1_dz_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mant_d = MantW'(in_den << (LodW'(DEN_W - 1) - lod_p));
        s1_exp_d  = lod_found ? EXP_W'(lod_p) - EXP_W'(DEN_FRAC) : '0;
        s1_dz_d   = ~lod_found;
      end
    end
  end

  assign s2_sel   = s1_dz_q ? '0 : {1'b0, s1_mant_q[MantW-1 -: 3]};
  assign s2_frac  = s1_mant_q[MantW-4 -: FRAC_W];
  assign s2_slope = recip_slope(s2_sel);

  // S2: segment lookup and slope multiply.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.prod = $signed({{(PROD_W - M_W){s2_slope[M_W-1]}}, s2_slope}) *
                    $signed({{(PROD_W - FRAC_W){1'b0}}, s2_frac});
        s2_d.c    = recip_intercept(s2_sel);
        s2_d.exp  = s1_exp_q;
        s2_d.dz   = s1_dz_q;
      end
    end
  end

  assign s3_prod_sh = s2_q.prod >>> PROD_SHIFT;
  assign s3_sum     = s2_q.c + {{(C_W - PROD_W){s3_prod_sh[PROD_W-1]}}, s3_prod_sh} + RoundAdd;

  // S3: clamp negative to zero, saturate overflow, else take the mantissa window.
  always_comb begin
    if (s2_q.dz) begin
      s3_recip = '1;
    end else if (s3_sum[C_W-1]) begin
      s3_recip = '0;
    end else if ((s3_sum >> SliceHi) != '0) begin
      s3_recip = '1;
    end else begin
      s3_recip = s3_sum[SliceHi-1:RES_LSB];
    end
  end

  // Output register: load on advance, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_recip_d = out_recip_q;
    out_exp_d   = out_exp_q;
    out_dz_d    = out_dz_q;
    if (s3_adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_recip_d = s3_recip;
        out_exp_d   = s2_q.exp;
        out_dz_d    = s2_q.dz;
      end
    end
  end

  // Pipeline state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_dz_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_recip_q <= '0;
      out_exp_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_exp_q    <= s1_exp_d;
      s1_dz_q     <= s1_dz_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_recip_q <= out_recip_d;
      out_exp_q   <= out_exp_d;
      out_dz_q    <= out_dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_recip = out_recip_q;
  assign out_exp   = out_exp_q;
  assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_softermax_recip_unit.sv
// Self-checking bench for softermax_recip_unit: reference model from reciprocal arithmetic,
// in-order scoreboard checked every cycle, plus literal expectations for key vectors.
module tb_softermax_recip_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_den = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_recip;
  logic [5:0]  out_exp;
  logic        out_dz;

  int checks = 0;
  int failures = 0;
  int stall_seen = 0;
  logic [22:0] exp_q[$];

  softermax_recip_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_den   (in_den),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_recip(out_recip),
    .out_exp  (out_exp),
    .out_dz   (out_dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected {dz, exp, recip}: piecewise-linear 1/x over eight segments of [1,2).
  function automatic logic [22:0] model(input logic [15:0] den);
    int p;
    logic [15:0] mant;
    int s, frac;
    longint c0, c1, m, prod, sh, sum;
    logic [15:0] r;
    logic [5:0] e;
    if (den == 16'd0) return {1'b1, 6'd0, 16'hFFFF};
    p = 0;
    for (int i = 0; i < 16; i++) if (den[i]) p = i;
    e = 6'(p - 8);
    mant = den << (15 - p);
    s = int'(mant[14:12]);
    frac = int'(mant[11:0]);
    c0 = (longint'(1) << 21) / (8 + s);
    c1 = (longint'(1) << 21) / (9 + s);
    m = c1 - c0;
    prod = m * frac;
    sh = (prod >= 0) ? prod / 4096 : -((-prod + 4095) / 4096);
    sum = c0 + sh;
`ifdef SOFTERMAX_RECIP_ROUND_EN
    sum = sum + 32;
`endif
    if (sum < 0) r = 16'd0;
    else if (sum >= (longint'(1) << 22)) r = 16'hFFFF;
    else r = 16'(sum / 64);
    return {1'b0, e, r};
  endfunction

  // Scoreboard: compare the head entry whenever output is valid; push on input acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("in_ready_vs_occupancy", {31'd0, in_ready},
          {31'd0, !(exp_q.size() >= 3 && !out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("stream_output", {9'd0, out_dz, out_exp, out_recip}, {9'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_den));
    end
  end

  task automatic single(input string name, input logic [15:0] den, input logic [15:0] r,
                        input logic [5:0] e, input logic dz);
    int lat;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_den    = den;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, lat, 32'd3);
    chk({name, "_recip"}, {16'd0, out_recip}, {16'd0, r});
    chk({name, "_exp"}, {26'd0, out_exp}, {26'd0, e});
    chk({name, "_dz"}, {31'd0, out_dz}, {31'd0, dz});
  endtask

  task automatic send(input logic [15:0] v);
    logic got;
    in_valid = 1'b1;
    in_den   = v;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      stall_seen++;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  logic [15:0] vec[8] = '{16'h0100, 16'h0180, 16'h0001, 16'hFFFF,
                          16'h0000, 16'h1234, 16'h00FF, 16'h7A5C};

  initial begin
    int highs;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_recip", {16'd0, out_recip}, 32'd0);
    chk("reset_out_exp", {26'd0, out_exp}, 32'd0);
    chk("reset_out_dz", {31'd0, out_dz}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    single("den_1p0", 16'h0100, 16'h1000, 6'd0, 1'b0);
`ifdef SOFTERMAX_RECIP_ROUND_EN
    single("den_1p5", 16'h0180, 16'd2731, 6'd0, 1'b0);
`else
    single("den_1p5", 16'h0180, 16'd2730, 6'd0, 1'b0);
`endif
    single("den_min", 16'h0001, 16'h1000, 6'h38, 1'b0);
    single("den_max", 16'hFFFF, 16'd2048, 6'd7, 1'b0);
    single("den_zero", 16'h0000, 16'hFFFF, 6'd0, 1'b1);

    // Back-to-back stream with a 5-cycle downstream stall.
    @(posedge clk);
    #1;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vec[i]);
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("stall_in_ready_low", {31'd0, stall_seen > 0}, 32'd1);
    drain("stall_drain");

    // Reset with two transfers in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_den    = 16'h0200;
    @(posedge clk);
    #1;
    in_den = 16'h0300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    chk("midreset_no_stale", highs, 32'd0);

    // Random values under random backpressure.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 24; i++) send(16'($urandom_range(0, 16'hFFFF)));
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

endmodule
